// File: rtl/ad7124_pkg.sv
// Shared constants and state encoding for the AD7124 conversion scheduler.
// Command bytes, frame lengths and the scheduler FSM states live here.
package ad7124_pkg;

  localparam logic [7:0] AD7124_CMD_RD_STATUS = 8'h40;
  localparam logic [7:0] AD7124_CMD_RD_DATA   = 8'h42;
  localparam int         AD7124_RDY_BIT       = 7;
  localparam logic [5:0] LEN_STATUS           = 6'd16;
  localparam logic [5:0] LEN_DATA             = 6'd32;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ARB,
    S_POLL_CMD,
    S_POLL_RSP,
    S_READ_CMD,
    S_READ_RSP,
    S_STORE,
    S_NEXT,
    S_SW_CMD,
    S_SW_RSP
  } state_t;

endpackage

// File: rtl/ad7124_tc_scheduler.sv
// Round-robin AD7124 status/data sweep sharing one SPI engine with
// software register accesses; results land in the sample BRAM.
module ad7124_tc_scheduler
  import ad7124_pkg::*;
#(
  parameter int NUM_OF_TC_PER_BOARD = 8,
  parameter int BRAM_BASE           = 0,
  parameter int STALE_LIMIT         = 16,
  localparam int CSW = $clog2(NUM_OF_TC_PER_BOARD)
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic                           enable,
  input  logic                           sw_req_valid,
  output logic                           sw_req_ready,
  input  logic [CSW-1:0]                 sw_req_cs,
  input  logic [5:0]                     sw_req_len,
  input  logic [31:0]                    sw_req_data,
  output logic                           sw_rsp_valid,
  output logic [31:0]                    sw_rsp_data,
  output logic                           spi_cmd_valid,
  input  logic                           spi_cmd_ready,
  output logic [CSW-1:0]                 spi_cmd_cs,
  output logic [5:0]                     spi_cmd_len,
  output logic [31:0]                    spi_cmd_data,
  input  logic                           spi_rsp_valid,
  input  logic [31:0]                    spi_rsp_data,
  output logic                           bram_en,
  output logic [3:0]                     bram_we,
  output logic [12:0]                    bram_addr,
  output logic [31:0]                    bram_wrdata,
  output logic [NUM_OF_TC_PER_BOARD-1:0] stale_mask,
  output logic                           sweep_done,
  output logic                           busy
);

  localparam logic [7:0] LIM = 8'(STALE_LIMIT);

  state_t         r_state;
  state_t         w_next;
  logic [CSW-1:0] r_ch;
  logic [7:0]     r_seq;
  logic [23:0]    r_sample;
  logic [CSW-1:0] r_sw_cs;
  logic [5:0]     r_sw_len;
  logic [31:0]    r_sw_data;
  logic           r_sw_rsp_valid;
  logic [31:0]    r_sw_rsp_data;
  logic           w_last;
  logic           w_not_rdy;
  logic           w_poll_nr;
  logic           w_read_ok;

  assign w_last    = (r_ch == CSW'(NUM_OF_TC_PER_BOARD - 1));
  assign w_not_rdy = spi_rsp_data[AD7124_RDY_BIT];
  assign w_poll_nr = (r_state == S_POLL_RSP) && spi_rsp_valid
                     && w_not_rdy;
  assign w_read_ok = (r_state == S_READ_RSP) && spi_rsp_valid;

  assign busy         = (r_state != S_IDLE);
  assign sw_rsp_valid = r_sw_rsp_valid;
  assign sw_rsp_data  = r_sw_rsp_data;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state        <= S_IDLE;
      r_ch           <= '0;
      r_seq          <= '0;
      r_sample       <= '0;
      r_sw_cs        <= '0;
      r_sw_len       <= '0;
      r_sw_data      <= '0;
      r_sw_rsp_valid <= 1'b0;
      r_sw_rsp_data  <= '0;
    end else begin
      r_state        <= w_next;
      r_sw_rsp_valid <= 1'b0;
      if (r_state == S_ARB && sw_req_valid) begin
        r_sw_cs   <= sw_req_cs;
        r_sw_len  <= sw_req_len;
        r_sw_data <= sw_req_data;
      end
      if (w_read_ok)
        r_sample <= spi_rsp_data[23:0];
      if (r_state == S_SW_RSP && spi_rsp_valid) begin
        r_sw_rsp_valid <= 1'b1;
        r_sw_rsp_data  <= spi_rsp_data;
      end
      if (r_state == S_NEXT) begin
        if (w_last) begin
          r_ch  <= '0;
          r_seq <= r_seq + 8'd1;
        end else begin
          r_ch <= r_ch + CSW'(1);
        end
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    spi_cmd_valid = 1'b0;
    spi_cmd_cs    = '0;
    spi_cmd_len   = '0;
    spi_cmd_data  = '0;
    sw_req_ready  = 1'b0;
    bram_en       = 1'b0;
    bram_we       = '0;
    bram_addr     = '0;
    bram_wrdata   = '0;
    sweep_done    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (enable || sw_req_valid)
          w_next = S_ARB;
      end
      // software wins only here, between channels
      S_ARB: begin
        if (sw_req_valid) begin
          sw_req_ready = 1'b1;
          w_next       = S_SW_CMD;
        end else if (enable) begin
          w_next = S_POLL_CMD;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_POLL_CMD: begin
        spi_cmd_valid = 1'b1;
        spi_cmd_cs    = r_ch;
        spi_cmd_len   = LEN_STATUS;
        spi_cmd_data  = {AD7124_CMD_RD_STATUS, 24'h0};
        if (spi_cmd_ready)
          w_next = S_POLL_RSP;
      end
      S_POLL_RSP: begin
        if (spi_rsp_valid)
          w_next = w_not_rdy ? S_NEXT : S_READ_CMD;
      end
      S_READ_CMD: begin
        spi_cmd_valid = 1'b1;
        spi_cmd_cs    = r_ch;
        spi_cmd_len   = LEN_DATA;
        spi_cmd_data  = {AD7124_CMD_RD_DATA, 24'h0};
        if (spi_cmd_ready)
          w_next = S_READ_RSP;
      end
      S_READ_RSP: begin
        if (spi_rsp_valid)
          w_next = S_STORE;
      end
      S_STORE: begin
        bram_en     = 1'b1;
        bram_we     = 4'hF;
        bram_addr   = 13'(BRAM_BASE) + 13'({r_ch, 2'b00});
        bram_wrdata = {r_seq, r_sample};
        w_next      = S_NEXT;
      end
      S_NEXT: begin
        sweep_done = w_last;
        w_next     = S_ARB;
      end
      S_SW_CMD: begin
        spi_cmd_valid = 1'b1;
        spi_cmd_cs    = r_sw_cs;
        spi_cmd_len   = r_sw_len;
        spi_cmd_data  = r_sw_data;
        if (spi_cmd_ready)
          w_next = S_SW_RSP;
      end
      S_SW_RSP: begin
        if (spi_rsp_valid)
          w_next = S_ARB;
      end
      default: w_next = S_IDLE;
    endcase
  end

  for (genvar i = 0; i < NUM_OF_TC_PER_BOARD; i++) begin : g_stale
    logic [7:0] r_cnt;
    logic       r_flag;
    logic       w_sel;

    assign w_sel         = (r_ch == CSW'(i));
    assign stale_mask[i] = r_flag;

    // counter saturates at the limit; flag rises on reaching it
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        r_cnt  <= '0;
        r_flag <= 1'b0;
      end else if (w_sel && w_read_ok) begin
        r_cnt  <= '0;
        r_flag <= 1'b0;
      end else if (w_sel && w_poll_nr && r_cnt != LIM) begin
        r_cnt <= r_cnt + 8'd1;
        if (r_cnt == LIM - 8'd1)
          r_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ad7124_tc_scheduler.sv
// Bench for ad7124_tc_scheduler: randomized SPI engine with a
// channel-level model of the sweep, stale tracking and BRAM results.
module tb_ad7124_tc_scheduler;

  localparam int N   = 8;
  localparam int LIM = 16;

  typedef struct packed {
    logic [12:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        enable = 1'b0;
  logic        sw_req_valid = 1'b0;
  logic        sw_req_ready;
  logic [2:0]  sw_req_cs = '0;
  logic [5:0]  sw_req_len = '0;
  logic [31:0] sw_req_data = '0;
  logic        sw_rsp_valid;
  logic [31:0] sw_rsp_data;
  logic        spi_cmd_valid;
  logic        spi_cmd_ready;
  logic [2:0]  spi_cmd_cs;
  logic [5:0]  spi_cmd_len;
  logic [31:0] spi_cmd_data;
  logic        spi_rsp_valid;
  logic [31:0] spi_rsp_data;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [12:0] bram_addr;
  logic [31:0] bram_wrdata;
  logic [7:0]  stale_mask;
  logic        sweep_done;
  logic        busy;

  wire [159:0] outs = {spi_cmd_valid, spi_cmd_cs, spi_cmd_len,
    spi_cmd_data, sw_req_ready, sw_rsp_valid, sw_rsp_data,
    bram_en, bram_we, bram_addr, bram_wrdata, stale_mask,
    sweep_done, busy, 14'h0};

  int errors = 0;
  int checks = 0;

  // engine knobs and state
  bit          hold = 1'b0;
  logic [7:0]  nr_mask = '0;
  bit          fixed_data = 1'b0;
  int          pend = 0;
  int          dly = 0;
  int          pkind = 0;
  int          pcs = 0;
  logic [31:0] pdata = '0;
  int          log_kind[$];
  int          log_cs[$];
  int          sw_seen_writes = 0;

  // software request expectations
  logic [2:0]  sw_e_cs = '0;
  logic [5:0]  sw_e_len = '0;
  logic [31:0] sw_e_data = '0;
  logic [31:0] sw_e_rsp = '0;

  // channel-level reference model
  int          m_ch = 0;
  int          m_seq = 0;
  int          m_cnt[N];
  logic [7:0]  m_stale = '0;
  bit          m_need_read = 1'b0;
  int          m_done_exp = 0;
  int          np_cnt[N];
  wr_t         exp_q[$];
  wr_t         got_q[$];
  int          done_got = 0;

  ad7124_tc_scheduler #(
    .NUM_OF_TC_PER_BOARD(N),
    .BRAM_BASE(0),
    .STALE_LIMIT(LIM)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable),
    .sw_req_valid(sw_req_valid), .sw_req_ready(sw_req_ready),
    .sw_req_cs(sw_req_cs), .sw_req_len(sw_req_len),
    .sw_req_data(sw_req_data), .sw_rsp_valid(sw_rsp_valid),
    .sw_rsp_data(sw_rsp_data), .spi_cmd_valid(spi_cmd_valid),
    .spi_cmd_ready(spi_cmd_ready), .spi_cmd_cs(spi_cmd_cs),
    .spi_cmd_len(spi_cmd_len), .spi_cmd_data(spi_cmd_data),
    .spi_rsp_valid(spi_rsp_valid), .spi_rsp_data(spi_rsp_data),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wrdata(bram_wrdata), .stale_mask(stale_mask),
    .sweep_done(sweep_done), .busy(busy)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic m_advance();
    if (m_ch == N - 1) begin
      m_ch = 0;
      m_seq = (m_seq + 1) % 256;
      m_done_exp++;
    end else begin
      m_ch++;
    end
  endtask

  task automatic eng_accept();
    int k;
    if (spi_cmd_len == 6'd16 && spi_cmd_data == 32'h4000_0000) k = 0;
    else if (spi_cmd_len == 6'd32 && spi_cmd_data == 32'h4200_0000) k = 1;
    else k = 2;
    checks++;
    if (k == 0) begin
      if (spi_cmd_cs !== 3'(m_ch) || m_need_read) begin
        errors++;
        $display("FAIL poll_cmd: cs=%0d read_pending=%0b, required cs=%0d pending=0",
          spi_cmd_cs, m_need_read, m_ch);
      end
      pdata = $urandom;
      pdata[7] = nr_mask[spi_cmd_cs];
    end else if (k == 1) begin
      if (spi_cmd_cs !== 3'(m_ch) || !m_need_read) begin
        errors++;
        $display("FAIL read_cmd: cs=%0d read_pending=%0b, required cs=%0d pending=1",
          spi_cmd_cs, m_need_read, m_ch);
      end
      pdata = $urandom;
      if (fixed_data) pdata[23:0] = 24'h123456 + 24'(spi_cmd_cs);
    end else begin
      if ({spi_cmd_cs, spi_cmd_len, spi_cmd_data} !==
          {sw_e_cs, sw_e_len, sw_e_data}) begin
        errors++;
        $display("FAIL sw_cmd: got %0d/%0d/%h, required %0d/%0d/%h",
          spi_cmd_cs, spi_cmd_len, spi_cmd_data,
          sw_e_cs, sw_e_len, sw_e_data);
      end
      pdata = sw_e_rsp;
      sw_seen_writes = got_q.size();
    end
    pkind = k;
    pcs = int'(spi_cmd_cs);
    dly = $urandom_range(0, 3);
    pend = 1;
    log_kind.push_back(k);
    log_cs.push_back(pcs);
  endtask

  task automatic eng_respond();
    wr_t w;
    if (pkind == 0) begin
      if (pdata[7]) begin
        np_cnt[m_ch]++;
        if (m_cnt[m_ch] < LIM) m_cnt[m_ch]++;
        if (m_cnt[m_ch] == LIM) m_stale[m_ch] = 1'b1;
        m_advance();
      end else begin
        m_need_read = 1'b1;
      end
    end else if (pkind == 1) begin
      w.addr = 13'(4 * m_ch);
      w.data = {8'(m_seq), pdata[23:0]};
      exp_q.push_back(w);
      m_cnt[m_ch] = 0;
      m_stale[m_ch] = 1'b0;
      m_need_read = 1'b0;
      m_advance();
    end
  endtask

  // SPI engine: single outstanding command, random ready and latency
  initial begin
    spi_cmd_ready = 1'b0;
    spi_rsp_valid = 1'b0;
    spi_rsp_data = '0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        spi_cmd_ready = 1'b0;
        spi_rsp_valid = 1'b0;
        pend = 0;
        m_ch = 0;
        m_seq = 0;
        m_stale = '0;
        m_need_read = 1'b0;
        m_done_exp = 0;
        done_got = 0;
        exp_q.delete();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end else begin
        spi_rsp_valid = 1'b0;
        if (pend != 0) begin
          spi_cmd_ready = 1'b0;
          if (dly > 0) begin
            dly--;
          end else begin
            spi_rsp_valid = 1'b1;
            spi_rsp_data = pdata;
            pend = 0;
            eng_respond();
          end
        end else begin
          spi_cmd_ready = !hold && ($urandom_range(0, 3) != 0);
          if (spi_cmd_ready && spi_cmd_valid) eng_accept();
        end
      end
    end
  end

  // BRAM / sweep_done / stale monitor
  initial begin
    wr_t e;
    wr_t g;
    forever begin
      tick();
      if (aresetn) begin
        if (bram_en) begin
          g.addr = bram_addr;
          g.data = bram_wrdata;
          got_q.push_back(g);
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL bram_unexpected: addr=%h data=%h, required no write",
              bram_addr, bram_wrdata);
          end else begin
            e = exp_q.pop_front();
            if ({bram_we, bram_addr, bram_wrdata} !==
                {4'hF, e.addr, e.data}) begin
              errors++;
              $display("FAIL bram_write: we=%h addr=%h data=%h, required F/%h/%h",
                bram_we, bram_addr, bram_wrdata, e.addr, e.data);
            end
          end
        end
        if (sweep_done) done_got++;
        checks++;
        if (stale_mask !== m_stale) begin
          errors++;
          $display("FAIL stale_mask: got %h, required %h",
            stale_mask, m_stale);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  task automatic do_sw(input logic [2:0] cs, input logic [5:0] len,
                       input logic [31:0] data, output logic [31:0] rsp,
                       output bit to, output logic rdy_after);
    int n;
    sw_e_cs = cs;
    sw_e_len = len;
    sw_e_data = data;
    sw_req_cs = cs;
    sw_req_len = len;
    sw_req_data = data;
    sw_req_valid = 1'b1;
    to = 1'b0;
    n = 0;
    #1;
    while (!sw_req_ready && n < 300) begin
      @(posedge aclk);
      #2;
      n++;
    end
    if (!sw_req_ready) to = 1'b1;
    @(posedge aclk);
    #1;
    sw_req_valid = 1'b0;
    #1;
    rdy_after = sw_req_ready;
    n = 0;
    while (!sw_rsp_valid && n < 300) begin
      tick();
      n++;
    end
    if (!sw_rsp_valid) to = 1'b1;
    rsp = sw_rsp_data;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy=%b, required 0", nm, busy);
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0", outs);
    end
    aresetn = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_happy();
    int n = 0;
    int d0;
    logic [31:0] ed;
    nr_mask = '0;
    fixed_data = 1'b1;
    got_q.delete();
    d0 = done_got;
    enable = 1'b1;
    while (got_q.size() < 16 && n < 3000) begin
      tick();
      n++;
    end
    enable = 1'b0;
    checks++;
    if (got_q.size() < 16) begin
      errors++;
      $display("FAIL happy_timeout: writes=%0d, required 16", got_q.size());
    end
    wait_idle("happy_idle");
    checks++;
    if (got_q.size() != 16 || done_got - d0 != 2) begin
      errors++;
      $display("FAIL happy_counts: writes=%0d sweeps=%0d, required 16 and 2",
        got_q.size(), done_got - d0);
    end
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      ed = {(i < 8) ? 8'h00 : 8'h01, 24'h123456 + 24'(i % 8)};
      checks++;
      if (got_q[i].addr !== 13'(4 * (i % 8)) || got_q[i].data !== ed) begin
        errors++;
        $display("FAIL happy_write%0d: addr=%h data=%h, required %h/%h",
          i, got_q[i].addr, got_q[i].data, 13'(4 * (i % 8)), ed);
      end
    end
    fixed_data = 1'b0;
  endtask

  task automatic test_not_ready();
    int n = 0;
    bit hit12 = 1'b0;
    np_cnt[3] = 0;
    nr_mask = 8'h08;
    got_q.delete();
    enable = 1'b1;
    while (np_cnt[3] < 15 && n < 5000) begin
      tick();
      n++;
    end
    checks++;
    if (np_cnt[3] != 15 || stale_mask !== 8'h00) begin
      errors++;
      $display("FAIL stale_before_limit: polls=%0d mask=%h, required 15/00",
        np_cnt[3], stale_mask);
    end
    n = 0;
    while (np_cnt[3] < 16 && n < 1000) begin
      tick();
      n++;
    end
    checks++;
    if (stale_mask !== 8'h08) begin
      errors++;
      $display("FAIL stale_at_limit: mask=%h, required 08", stale_mask);
    end
    foreach (got_q[i]) if (got_q[i].addr == 13'd12) hit12 = 1'b1;
    checks++;
    if (hit12) begin
      errors++;
      $display("FAIL not_ready_write: ch3 written=1, required 0");
    end
    nr_mask = '0;
    got_q.delete();
    n = 0;
    while (!hit12 && n < 1000) begin
      tick();
      n++;
      foreach (got_q[i]) if (got_q[i].addr == 13'd12) hit12 = 1'b1;
    end
    checks++;
    if (!hit12 || stale_mask !== 8'h00) begin
      errors++;
      $display("FAIL stale_clear: written=%0b mask=%h, required 1/00",
        hit12, stale_mask);
    end
  endtask

  task automatic test_sw_priority();
    int n = 0;
    int idx;
    logic [31:0] r;
    bit to;
    logic ra;
    while (!(pend != 0 && pkind == 1 && pcs == 2) && n < 2000) begin
      tick();
      n++;
    end
    idx = log_kind.size() - 1;
    sw_e_rsp = 32'h00AB_CDEF;
    do_sw(3'd5, 6'd24, 32'h0A12_3400, r, to, ra);
    checks++;
    if (to || r !== 32'h00AB_CDEF) begin
      errors++;
      $display("FAIL sw_rsp: data=%h timeout=%0b, required 00abcdef/0", r, to);
    end
    checks++;
    if (ra !== 1'b0) begin
      errors++;
      $display("FAIL sw_ready_pulse: ready=%b after accept, required 0", ra);
    end
    checks++;
    if (log_kind.size() < idx + 2 || log_kind[idx + 1] != 2
        || log_cs[idx + 1] != 5) begin
      errors++;
      $display("FAIL sw_order: command after ch2 read is not sw cs5, required sw cs5");
    end
    checks++;
    if (sw_seen_writes == 0 || got_q[sw_seen_writes - 1].addr !== 13'd8) begin
      errors++;
      $display("FAIL sw_after_store: writes=%0d, required ch2 store first",
        sw_seen_writes);
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    int base;
    logic [40:0] f;
    hold = 1'b1;
    tick();
    while (!spi_cmd_valid && n < 200) begin
      tick();
      n++;
    end
    f = {spi_cmd_cs, spi_cmd_len, spi_cmd_data};
    base = log_kind.size();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (!spi_cmd_valid || {spi_cmd_cs, spi_cmd_len, spi_cmd_data} !== f
          || log_kind.size() != base) begin
        errors++;
        $display("FAIL bp_stable%0d: valid=%b fields=%h, required 1/%h",
          i, spi_cmd_valid, {spi_cmd_cs, spi_cmd_len, spi_cmd_data}, f);
      end
    end
    hold = 1'b0;
    n = 0;
    while (log_kind.size() == base && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (log_kind.size() != base + 1 || spi_cmd_valid !== 1'b0
        || log_cs[base] != int'(f[40:38])) begin
      errors++;
      $display("FAIL bp_accept: accepted=%0d valid=%b, required 1 and 0",
        log_kind.size() - base, spi_cmd_valid);
    end
  endtask

  task automatic test_disable_mid_read();
    int n = 0;
    int base;
    nr_mask = '0;
    while (!(pend != 0 && pkind == 0 && pcs == 6) && n < 2000) begin
      tick();
      n++;
    end
    hold = 1'b1;
    n = 0;
    while (!(spi_cmd_valid && spi_cmd_len == 6'd32 && spi_cmd_cs == 3'd6)
           && n < 200) begin
      tick();
      n++;
    end
    got_q.delete();
    enable = 1'b0;
    tick();
    hold = 1'b0;
    wait_idle("disable_idle");
    checks++;
    if (got_q.size() != 1 || got_q[0].addr !== 13'd24) begin
      errors++;
      $display("FAIL disable_store: writes=%0d, required one ch6 write",
        got_q.size());
    end
    base = log_kind.size();
    enable = 1'b1;
    n = 0;
    while (log_kind.size() == base && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (log_kind.size() == base || log_kind[base] != 0 || log_cs[base] != 7) begin
      errors++;
      $display("FAIL resume_ch: first command after re-enable not poll ch7");
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int base;
    nr_mask = 8'h80;
    while (!stale_mask[7] && n < 8000) begin
      tick();
      n++;
    end
    nr_mask = '0;
    n = 0;
    while (!(pend != 0 && pkind == 0) && n < 200) begin
      tick();
      n++;
    end
    aresetn = 1'b0;
    #1;
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %h, required 0", outs);
    end
    base = log_kind.size();
    got_q.delete();
    tick();
    aresetn = 1'b1;
    n = 0;
    while (got_q.size() == 0 && n < 500) begin
      tick();
      n++;
    end
    checks++;
    if (log_kind.size() == base || log_kind[base] != 0 || log_cs[base] != 0) begin
      errors++;
      $display("FAIL reset_restart_ch: first command not poll ch0");
    end
    checks++;
    if (got_q.size() == 0 || got_q[0].addr !== 13'd0
        || got_q[0].data[31:24] !== 8'h00) begin
      errors++;
      $display("FAIL reset_restart_seq: first write not ch0 seq0");
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [31:0] d;
    bit to;
    logic ra;
    for (int it = 0; it < 120; it++) begin
      if ($urandom_range(0, 3) == 0) nr_mask = 8'($urandom & $urandom);
      enable = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 2) == 0) begin
        d = $urandom;
        if (d[31:24] == 8'h40 || d[31:24] == 8'h42) d[31] = 1'b1;
        sw_e_rsp = $urandom;
        do_sw(3'($urandom_range(0, 7)), 6'($urandom_range(8, 32)),
              d, r, to, ra);
        checks++;
        if (to || r !== sw_e_rsp) begin
          errors++;
          $display("FAIL rand_sw%0d: data=%h timeout=%0b, required %h/0",
            it, r, to, sw_e_rsp);
        end
      end
      repeat ($urandom_range(1, 20)) tick();
    end
    enable = 1'b0;
    wait_idle("rand_idle");
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0 || done_got != m_done_exp) begin
      errors++;
      $display("FAIL rand_totals: pending=%0d sweeps=%0d, required 0 and %0d",
        exp_q.size(), done_got, m_done_exp);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0;
      np_cnt[i] = 0;
    end
    test_reset();
    test_happy();
    test_not_ready();
    test_sw_priority();
    test_backpressure();
    test_disable_mid_read();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
